// File: rtl/shot_resolver.sv
// Light-gun shot resolver: after a trigger press it shows one black frame, then one
// frame per live target, and reports which target (if any) the photodiode saw.
module shot_resolver #(
  parameter int N_TARGETS   = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DETECT_MIN  = 64,
  parameter int SHOTS       = 3,
  localparam int IDX_W  = (N_TARGETS > 1) ? $clog2(N_TARGETS) : 1,
  localparam int SHOT_W = (SHOTS > 0) ? $clog2(SHOTS + 1) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 trigger,
  input  logic                 detect,
  input  logic                 frame_tick,
  input  logic                 valid,
  input  logic [N_TARGETS-1:0] target_en,
  input  logic                 reload,
  output logic [1:0]           flash_mode,
  output logic [IDX_W-1:0]     target_sel,
  output logic                 hit,
  output logic [IDX_W-1:0]     hit_idx,
  output logic                 miss,
  output logic                 busy,
  output logic [SHOT_W-1:0]    shots_left
);

  localparam int CNT_W = $clog2(DETECT_MIN + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_BLACK, S_TARGET, S_RESULT, S_COOLDOWN
  } state_t;

  typedef enum logic [1:0] {
    FLASH_NORMAL = 2'd0,
    FLASH_BLACK  = 2'd1,
    FLASH_TARGET = 2'd2
  } flash_t;

  state_t                 state_q, state_d;
  flash_t                 flash_c;
  logic [SYNC_STAGES-1:0] trig_sync, det_sync;
  logic                   trig_s, det_s, trig_prev, trig_rise;
  logic [CNT_W-1:0]       light_cnt;
  logic                   lit;
  logic [N_TARGETS-1:0]   en_q, en_d;
  logic [IDX_W-1:0]       sel_q, sel_d, first_idx, next_idx;
  logic                   has_first, has_next;
  logic                   hit_c, miss_c;

  assign trig_s    = trig_sync[SYNC_STAGES-1];
  assign det_s     = det_sync[SYNC_STAGES-1];
  assign trig_rise = trig_s && !trig_prev;
  // Light for the frame just ended; the counter saturates, so >= and == agree.
  assign lit       = (light_cnt >= CNT_W'(DETECT_MIN));

  // NOTE: sequential state is only ever written with <= so every flop samples
  // pre-edge values regardless of process ordering in simulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      trig_sync <= '0;
      det_sync  <= '0;
      trig_prev <= 1'b0;
      light_cnt <= '0;
    end else begin
      trig_sync <= {trig_sync[SYNC_STAGES-2:0], trigger};
      det_sync  <= {det_sync[SYNC_STAGES-2:0], detect};
      trig_prev <= trig_s;
      if (frame_tick)
        light_cnt <= '0;
      else if (valid && det_s && !lit)
        light_cnt <= light_cnt + CNT_W'(1);
    end
  end

  // Lowest enabled target, and lowest enabled target above the one on screen.
  always_comb begin
    has_first = 1'b0;
    first_idx = '0;
    has_next  = 1'b0;
    next_idx  = '0;
    for (int i = N_TARGETS - 1; i >= 0; i--) begin
      if (en_q[i]) begin
        has_first = 1'b1;
        first_idx = IDX_W'(i);
      end
      if (en_q[i] && (i > int'(sel_q))) begin
        has_next = 1'b1;
        next_idx = IDX_W'(i);
      end
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    en_d    = en_q;
    flash_c = FLASH_NORMAL;
    hit_c   = 1'b0;
    miss_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trig_rise && (shots_left != '0)) begin
          state_d = S_ARM;
          en_d    = target_en;
        end
      end
      S_ARM: begin
        if (frame_tick) state_d = S_BLACK;
      end
      S_BLACK: begin
        flash_c = FLASH_BLACK;
        if (frame_tick) begin
          if (lit || !has_first) begin
            miss_c  = 1'b1;
            state_d = S_RESULT;
          end else begin
            sel_d   = first_idx;
            state_d = S_TARGET;
          end
        end
      end
      S_TARGET: begin
        flash_c = FLASH_TARGET;
        if (frame_tick) begin
          if (lit) begin
            hit_c   = 1'b1;
            sel_d   = '0;
            state_d = S_RESULT;
          end else if (has_next) begin
            sel_d = next_idx;
          end else begin
            miss_c  = 1'b1;
            sel_d   = '0;
            state_d = S_RESULT;
          end
        end
      end
      S_RESULT: begin
        state_d = S_COOLDOWN;
      end
      S_COOLDOWN: begin
        if (!trig_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      sel_q      <= '0;
      en_q       <= '0;
      hit_idx    <= '0;
      shots_left <= SHOT_W'(SHOTS);
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      if (hit_c) hit_idx <= sel_q;
      if (reload)
        shots_left <= SHOT_W'(SHOTS);
      else if ((state_q == S_RESULT) && (shots_left != '0))
        shots_left <= shots_left - SHOT_W'(1);
    end
  end

  // A reset cycle must never emit a result pulse, even if a tick coincides.
  assign hit        = hit_c && !reset;
  assign miss       = miss_c && !reset;
  assign flash_mode = flash_c;
  assign target_sel = sel_q;
  assign busy       = (state_q inside {S_ARM, S_BLACK, S_TARGET, S_RESULT});

endmodule
